// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, requester IDs,
// response-buffer state encoding and the opcode legality check.
package alu_arbiter_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // The buffer occupancy bit doubles as the state encoding.
  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: op_legal = 1'b1;
      default:                                    op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/thirtytwoBitALU.sv
// Combinational 32-bit ALU. op[2] selects subtract in the adder; set is the sign of
// the exact (33-bit) a+b or a-b, overflow is reported only for ADD and SUB.
module thirtytwoBitALU
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        set,
  output logic        zero,
  output logic        overflow
);

  logic [32:0] a_ext_s;
  logic [32:0] b_ext_s;
  logic [32:0] sum_s;
  logic        ovf_raw_s;

  always_comb begin
    a_ext_s   = {a[31], a};
    b_ext_s   = op[2] ? ~{b[31], b} : {b[31], b};
    sum_s     = a_ext_s + b_ext_s + {32'd0, op[2]};
    set       = sum_s[32];
    ovf_raw_s = sum_s[32] ^ sum_s[31];
    case (op)
      ALU_AND:          result = a & b;
      ALU_OR:           result = a | b;
      ALU_ADD, ALU_SUB: result = sum_s[31:0];
      ALU_SLT:          result = {31'd0, sum_s[32]};
      default:          result = 32'd0;
    endcase
    if ((op == ALU_ADD) || (op == ALU_SUB)) begin
      overflow = ovf_raw_s;
    end else begin
      overflow = 1'b0;
    end
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters, with a
// single-entry registered response buffer that can drain and reload in one cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [2:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [2:0]       r1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_set,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic             rsp_src
);

  rsp_state_e       state_q, state_d;
  logic             prio_q, prio_d;
  logic [WIDTH-1:0] result_q;
  logic             set_q, zero_q, ovf_q, err_q, src_q;

  logic             grant_valid_s, grant_id_s, can_accept_s, accept_s;
  logic [WIDTH-1:0] alu_a_s, alu_b_s, alu_result_s;
  logic [2:0]       alu_op_s;
  logic             alu_set_s, alu_zero_s, alu_ovf_s, legal_s;

  // Grant selection: a lone requester wins, a tie goes to the priority holder.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = REQ0;
    if (r0_valid && r1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = prio_q;
    end else if (r0_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = REQ0;
    end else if (r1_valid) begin
      grant_valid_s = 1'b1;
      grant_id_s    = REQ1;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = REQ0;
    end
  end

  // Nothing is accepted while reset is asserted, so ready is gated by rst_n.
  assign can_accept_s = (state_q == RSP_EMPTY) || rsp_ready;
  assign accept_s     = rst_n && grant_valid_s && can_accept_s;
  assign r0_ready     = accept_s && (grant_id_s == REQ0);
  assign r1_ready     = accept_s && (grant_id_s == REQ1);

  // Operand mux in front of the shared ALU.
  always_comb begin
    alu_a_s  = (grant_id_s == REQ1) ? r1_a  : r0_a;
    alu_b_s  = (grant_id_s == REQ1) ? r1_b  : r0_b;
    alu_op_s = (grant_id_s == REQ1) ? r1_op : r0_op;
    legal_s  = op_legal(alu_op_s);
  end

  thirtytwoBitALU u_alu (
    .a        (alu_a_s),
    .b        (alu_b_s),
    .op       (alu_op_s),
    .result   (alu_result_s),
    .set      (alu_set_s),
    .zero     (alu_zero_s),
    .overflow (alu_ovf_s)
  );

  // Next state for buffer occupancy and round-robin priority.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    if (accept_s) begin
      prio_d = ~grant_id_s;
    end else begin
      prio_d = prio_q;
    end
    case (state_q)
      RSP_EMPTY: begin
        if (accept_s) state_d = RSP_FULL;
        else          state_d = RSP_EMPTY;
      end
      RSP_FULL: begin
        if (accept_s)       state_d = RSP_FULL;
        else if (rsp_ready) state_d = RSP_EMPTY;
        else                state_d = RSP_FULL;
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  // State and priority registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RSP_EMPTY;
      prio_q  <= RR_INIT;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // Response payload loads only on accept; a plain drain leaves it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      set_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      src_q    <= REQ0;
    end else if (accept_s) begin
      result_q <= legal_s ? alu_result_s : '0;
      set_q    <= legal_s && alu_set_s;
      zero_q   <= legal_s && alu_zero_s;
      ovf_q    <= legal_s && alu_ovf_s;
      err_q    <= ~legal_s;
      src_q    <= grant_id_s;
    end
  end

  assign rsp_valid    = (state_q == RSP_FULL);
  assign rsp_result   = result_q;
  assign rsp_set      = set_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign rsp_err      = err_q;
  assign rsp_src      = src_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// checked against an arithmetic reference model of the arbiter and ALU.
module tb_alu_arbiter;

  localparam logic [31:0] OPA = 32'h00000043;
  localparam logic [31:0] OPB = 32'h8000007F;

  logic        clk, rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_op, r1_op;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_set, rsp_zero, rsp_overflow, rsp_err, rsp_src;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        m_full, m_prio, m_set, m_zero, m_ovf, m_err, m_src;
  logic [31:0] m_result;
  logic        e_r0, e_r1;

  alu_arbiter #(.WIDTH(32), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_set(rsp_set), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .rsp_err(rsp_err), .rsp_src(rsp_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from plain signed arithmetic on 64-bit integers.
  task automatic alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic set, output logic zero,
                         output logic ovf, output logic err);
    longint sa, sb, exact;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    exact = op[2] ? (sa - sb) : (sa + sb);
    err = 1'b0; ovf = 1'b0; res = 32'd0;
    set = (exact < 64'sd0);
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010, 3'b110: begin
        res = exact[31:0];
        ovf = (exact > 64'sh7FFF_FFFF) || (exact < -64'sh8000_0000);
      end
      3'b111: res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin err = 1'b1; set = 1'b0; end
    endcase
    zero = !err && (res == 32'd0);
  endtask

  task automatic model_ready();
    logic can;
    can = !m_full || rsp_ready;
    e_r0 = 1'b0; e_r1 = 1'b0;
    if (rst_n && can) begin
      if (r0_valid && r1_valid) begin
        if (m_prio) e_r1 = 1'b1; else e_r0 = 1'b1;
      end else if (r0_valid) e_r0 = 1'b1;
      else if (r1_valid) e_r1 = 1'b1;
    end
  endtask

  // One clock: predict readies, take the edge, advance the model, settle.
  task automatic tick();
    model_ready();
    @(posedge clk);
    if (!rst_n) begin
      m_full = 1'b0; m_prio = 1'b0; m_result = 32'd0;
      m_set = 1'b0; m_zero = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_src = 1'b0;
    end else if (e_r0 || e_r1) begin
      if (e_r1) alu_ref(r1_op, r1_a, r1_b, m_result, m_set, m_zero, m_ovf, m_err);
      else      alu_ref(r0_op, r0_a, r0_b, m_result, m_set, m_zero, m_ovf, m_err);
      m_src = e_r1; m_full = 1'b1; m_prio = !e_r1;
    end else if (m_full && rsp_ready) begin
      m_full = 1'b0;
    end
    #1;
  endtask

  task automatic set_req(input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1);
    r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
    r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(5))
      0:       rand_operand = 32'h0000_0000;
      1:       rand_operand = 32'h7FFF_FFFF;
      2:       rand_operand = 32'h8000_0000;
      3:       rand_operand = 32'hFFFF_FFFF;
      default: rand_operand = $urandom;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b1;
    set_req(1'b1, 3'b010, OPA, OPB, 1'b1, 3'b001, OPA, OPB);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_ready got %b required 00", {r0_ready, r1_ready});
    end
    tick(); tick();
    tests_run++;
    if ({rsp_valid, rsp_result, rsp_set, rsp_zero, rsp_overflow, rsp_err, rsp_src} !== 38'd0) begin
      tests_failed++; $display("FAIL reset_state got v=%b res=%h src=%b required all zero", rsp_valid, rsp_result, rsp_src);
    end
    rst_n = 1'b1;
    set_req(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0);
    tick();
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    set_req(1'b1, 3'b010, OPA, OPB, 1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL single_add_ready got %b required 10", {r0_ready, r1_ready});
    end
    tick();
    tests_run++;
    if ({rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_src} !== {1'b1, 32'h800000C2, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL single_add_rsp got v=%b res=%h ovf=%b zero=%b src=%b required 1 800000c2 0 0 0",
                               rsp_valid, rsp_result, rsp_overflow, rsp_zero, rsp_src);
    end
    r0_valid = 1'b0;
    tick();
    tests_run++;
    if ({rsp_valid, rsp_result} !== {1'b0, 32'h800000C2}) begin
      tests_failed++; $display("FAIL drain_hold got v=%b res=%h required 0 800000c2", rsp_valid, rsp_result);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    rsp_ready = 1'b1;
    set_req(1'b1, 3'b000, OPA, OPB, 1'b1, 3'b001, OPA, OPB);
    for (int i = 0; i < 4; i++) begin
      logic exp_src;
      exp_src = (i % 2) == 1;
      #1;
      tests_run++;
      if ({r0_ready, r1_ready} !== {!exp_src, exp_src}) begin
        tests_failed++; $display("FAIL rr_ready[%0d] got %b required %b", i, {r0_ready, r1_ready}, {!exp_src, exp_src});
      end
      tick();
      tests_run++;
      if ({rsp_valid, rsp_src, rsp_result} !== {1'b1, exp_src, (exp_src ? OPB : OPA)}) begin
        tests_failed++; $display("FAIL rr_rsp[%0d] got v=%b src=%b res=%h required 1 %b %h",
                                 i, rsp_valid, rsp_src, rsp_result, exp_src, (exp_src ? OPB : OPA));
      end
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({r0_ready, r1_ready} !== 2'b00) begin
        tests_failed++; $display("FAIL stall_ready[%0d] got %b required 00", i, {r0_ready, r1_ready});
      end
      tick();
      tests_run++;
      if ({rsp_valid, rsp_src, rsp_result} !== {1'b1, 1'b1, OPB}) begin
        tests_failed++; $display("FAIL stall_hold[%0d] got v=%b src=%b res=%h required 1 1 %h", i, rsp_valid, rsp_src, rsp_result, OPB);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL drain_accept_ready got %b required 10", {r0_ready, r1_ready});
    end
    tick();
    tests_run++;
    if ({rsp_valid, rsp_src, rsp_result} !== {1'b1, 1'b0, OPA}) begin
      tests_failed++; $display("FAIL drain_accept_rsp got v=%b src=%b res=%h required 1 0 %h", rsp_valid, rsp_src, rsp_result, OPA);
    end
  endtask

  task automatic test_flags();
    logic [31:0] fa [3] = '{32'h7FFFFFFF, OPA, OPA};
    logic [31:0] fb [3] = '{32'h00000001, OPB, OPB};
    logic [2:0]  fo [3] = '{3'b010, 3'b111, 3'b110};
    logic [31:0] fr [3] = '{32'h80000000, 32'h00000000, 32'h7FFFFFC4};
    logic [2:0]  ff [3] = '{3'b001, 3'b010, 3'b000};  // {set, zero, overflow}
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, fo[i], fa[i], fb[i], 1'b0, 3'b000, 32'd0, 32'd0);
      tick();
      tests_run++;
      if ({rsp_valid, rsp_err, rsp_result, rsp_set, rsp_zero, rsp_overflow} !== {1'b1, 1'b0, fr[i], ff[i]}) begin
        tests_failed++; $display("FAIL flags[%0d] got v=%b err=%b res=%h szo=%b%b%b required 1 0 %h %b",
                                 i, rsp_valid, rsp_err, rsp_result, rsp_set, rsp_zero, rsp_overflow, fr[i], ff[i]);
      end
    end
  endtask

  task automatic test_illegal();
    rsp_ready = 1'b1;
    set_req(1'b0, 3'b000, 32'd0, 32'd0, 1'b1, 3'b011, OPA, OPB);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL illegal_ready got %b required 01", {r0_ready, r1_ready});
    end
    tick();
    tests_run++;
    if ({rsp_valid, rsp_err, rsp_src, rsp_result, rsp_set, rsp_zero, rsp_overflow} !== {3'b111, 32'd0, 3'b000}) begin
      tests_failed++; $display("FAIL illegal_rsp got v=%b err=%b src=%b res=%h szo=%b%b%b required 1 1 1 0 000",
                               rsp_valid, rsp_err, rsp_src, rsp_result, rsp_set, rsp_zero, rsp_overflow);
    end
    set_req(1'b1, 3'b010, OPA, OPB, 1'b1, 3'b010, OPA, OPB);
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL illegal_prio got %b required 10", {r0_ready, r1_ready});
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    rsp_ready = 1'b1;
    set_req(1'b1, 3'b010, OPA, OPB, 1'b0, 3'b001, OPA, OPB);
    tick();
    r1_valid = 1'b1; rsp_ready = 1'b0;
    tick();
    tests_run++;
    if (rsp_valid !== 1'b1) begin
      tests_failed++; $display("FAIL mid_stall_valid got %b required 1", rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_gate_ready got %b required 00", {r0_ready, r1_ready});
    end
    rsp_ready = 1'b0;
    tick();
    tests_run++;
    if ({rsp_valid, rsp_result, rsp_err, rsp_src} !== 35'd0) begin
      tests_failed++; $display("FAIL mid_stall_reset got v=%b res=%h err=%b src=%b required 0 0 0 0", rsp_valid, rsp_result, rsp_err, rsp_src);
    end
    rst_n = 1'b1;
    #1;
    tests_run++;
    if ({r0_ready, r1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL reset_prio got %b required 10", {r0_ready, r1_ready});
    end
    tick();
  endtask

  task automatic test_random();
    logic p0, p1, acc0, acc1;
    p0 = 1'b0; p1 = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!p0 && $urandom_range(3) != 0) begin
        p0 = 1'b1; r0_a = rand_operand(); r0_b = rand_operand(); r0_op = 3'($urandom_range(7));
      end
      if (!p1 && $urandom_range(3) != 0) begin
        p1 = 1'b1; r1_a = rand_operand(); r1_b = rand_operand(); r1_op = 3'($urandom_range(7));
      end
      r0_valid = p0; r1_valid = p1;
      rsp_ready = ($urandom_range(3) != 0);
      #1;
      model_ready();
      tests_run++;
      if ({r0_ready, r1_ready} !== {e_r0, e_r1}) begin
        tests_failed++; $display("FAIL rand_ready cyc=%0d got %b required %b", cyc, {r0_ready, r1_ready}, {e_r0, e_r1});
      end
      acc0 = e_r0; acc1 = e_r1;
      tick();
      tests_run++;
      if ({rsp_valid, rsp_result, rsp_set, rsp_zero, rsp_overflow, rsp_err, rsp_src} !==
          {m_full, m_result, m_set, m_zero, m_ovf, m_err, m_src}) begin
        tests_failed++;
        $display("FAIL rand_rsp cyc=%0d got v=%b res=%h s=%b z=%b o=%b e=%b src=%b required v=%b res=%h s=%b z=%b o=%b e=%b src=%b",
                 cyc, rsp_valid, rsp_result, rsp_set, rsp_zero, rsp_overflow, rsp_err, rsp_src,
                 m_full, m_result, m_set, m_zero, m_ovf, m_err, m_src);
      end
      if (acc0) p0 = 1'b0;
      if (acc1) p1 = 1'b0;
    end
  endtask

  initial begin
    m_full = 1'b0; m_prio = 1'b0; m_result = 32'd0;
    m_set = 1'b0; m_zero = 1'b0; m_ovf = 1'b0; m_err = 1'b0; m_src = 1'b0;
    e_r0 = 1'b0; e_r1 = 1'b0;
    rst_n = 1'b0; rsp_ready = 1'b0;
    set_req(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 32'd0);
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_flags();
    test_illegal();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU (thirtytwoBitALU: a, b, op[2:0] -> result, set, zero, overflow) between two requesters.
- Uses round-robin arbitration with a valid/ready handshake on each request port.
- Registers the ALU outputs into a single-entry response buffer with its own valid/ready handshake.
- Sits between the two issue sources (e.g. main datapath and address/branch unit) and the shared ALU.

Parameters:
- WIDTH, 32, operand/result width; fixed by the ALU, only 32 is supported.
- RR_INIT, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- r0_valid  in  1  requester 0 has a request
- r0_ready  out  1  requester 0 request accepted this cycle
- r0_a, r0_b  in  32 each  requester 0 operands
- r0_op  in  3  requester 0 ALU opcode
- r1_valid, r1_ready, r1_a, r1_b, r1_op  same as r0_*, for requester 1
- rsp_valid  out  1  response buffer full
- rsp_ready  in  1  consumer takes the response
- rsp_result  out  32  ALU result
- rsp_set, rsp_zero, rsp_overflow  out  1 each  ALU flags
- rsp_err  out  1  illegal opcode was issued
- rsp_src  out  1  requester that produced this response

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset: rsp_valid=0, rsp_result=0, all flags=0, rsp_err=0, rsp_src=0, prio=RR_INIT. A held response is discarded, and no request is accepted in a reset cycle.
- Legal opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. They pass to the ALU unchanged.
- can_accept = !rsp_valid || rsp_ready. A full buffer that is being drained accepts a new request in the same cycle.
- Grant, combinational:
  - only rX_valid high -> grant X.
  - both valid -> grant prio.
  - none valid -> no grant.
- rX_ready = grant==X && can_accept. ready depends on valid; valid never depends on ready.
- Requester contract: hold valid, a, b and op stable until ready.
- Accept (rX_valid && rX_ready), at the next edge:
  - buffer loads the ALU outputs computed from requester X's operands.
  - rsp_src=X, rsp_valid=1.
  - prio = ~X. prio changes only on an accept.
- Illegal opcode on accept: rsp_result=0, set=zero=overflow=0, rsp_err=1. Still counts as an accept, and prio still rotates.
- Latency: accept at edge N -> rsp_valid visible after edge N. Throughput is one op per cycle while rsp_ready stays high.
- Drain with no accept (rsp_valid && rsp_ready && no grant): rsp_valid -> 0; data fields hold their last values.
- Stall (rsp_valid && !rsp_ready): buffer and prio hold, both rX_ready=0.
- States, two, encoded by rsp_valid:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on drain+accept or on stall.
  - FULL -> EMPTY on drain without accept.
- No combinational path from rsp_ready to rsp_* outputs. The only combinational paths are rsp_ready -> rX_ready and rX_valid -> rY_ready.

Decomposition:
- Shared package/header holds:
  - opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - an op-legal check function.
  - requester-ID constants REQ0=0, REQ1=1.
- Sub-module: one instance of the existing thirtytwoBitALU, fed through a 2:1 operand mux selected by grant.
- Arbitration and the response buffer stay in alu_arbiter.

Test Plan:
- Single ADD: r0 a=32'h00000043, b=32'h8000007F, op=010, rsp_ready=1 -> r0_ready=1 in that cycle. Next cycle: rsp_valid=1, rsp_result=32'h800000C2, overflow=0, zero=0, rsp_src=0.
- Both requesters valid every cycle, rsp_ready=1, RR_INIT=0:
  - r0 AND of the pair above -> 32'h00000043.
  - r1 OR of the same pair -> 32'h8000007F.
  - Responses alternate src 0,1,0,1 with no idle cycles.
- Backpressure: hold rsp_ready=0 for 3 cycles with both valid -> r0_ready=r1_ready=0 and rsp_* stable. Raise rsp_ready -> drain and the next accept happen in the same cycle.
- Flags:
  - ADD 32'h7FFFFFFF+1 -> result 32'h80000000, overflow=1.
  - SLT a=32'h00000043, b=32'h8000007F -> result 0, zero=1, set=0.
  - SUB of the same pair -> 32'h7FFFFFC4, overflow=0.
- Illegal op=3'b011 on r1 -> rsp_err=1, result 0, rsp_src=1, prio moves to 0.
- Reset mid-stall: rsp_valid=1, rsp_ready=0, rst_n=0 for one edge -> rsp_valid=0, prio=RR_INIT, no ready asserted during reset.
